sha256_round_pipe: RTL

SHA256_ROUND_PIPE -- requirements
Module: sha256_round_pipe

---
 rtl/sha256_round_pipe.sv | 111 +++++++++++
 1 files changed

// File: rtl/sha256_round_pipe.sv
// SHA-256 round pipe: STAGES unrolled rounds, one registered slot per round.
// Latency STAGES cycles; slots load when empty or advancing, so bubbles collapse and a stall holds every slot.
module sha256_round_pipe #(
  parameter int STAGES      = 2,
  parameter int START_ROUND = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] rx_state,
  input  logic [511:0] w_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] tx_state,
  output logic [511:0] w_out
);

  typedef struct packed {
    logic [511:0] w;
    logic [255:0] st;
  } job_t;

  localparam logic [0:63][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic job_t sha_round(input job_t j, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2, w1, w14, w_new;
    job_t        r;
    {h, g, f, e, d, c, b, a} = j.st;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + j.w[31:0];
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    r.st = {g, f, e, d + t1, c, b, a, t1 + t2};
    w1  = j.w[63:32];
    w14 = j.w[479:448];
    w_new = (rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10)) + j.w[319:288]
          + (rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3)) + j.w[31:0];
    r.w = {w_new, j.w[511:32]};
    return r;
  endfunction

  logic [STAGES-1:0] vld_q, vld_d, load;
  job_t              job_q [STAGES];
  job_t              job_d [STAGES];
  job_t              rnd   [STAGES];
  job_t              in_job;

  assign in_job = '{w: w_in, st: rx_state};

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_round
    localparam int KI = START_ROUND + gi;
    if (gi == 0) begin : g_src
      assign rnd[gi] = sha_round(in_job, K_TAB[KI]);
    end else begin : g_src
      assign rnd[gi] = sha_round(job_q[gi-1], K_TAB[KI]);
    end
  end

  // A slot can load if it is empty or everything between it and the output can move.
  always_comb begin
    logic nxt;
    nxt  = out_ready;
    load = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load[i] = ~vld_q[i] | nxt;
      nxt     = load[i];
    end
  end

  always_comb begin
    logic up_vld;
    up_vld = in_valid;
    vld_d  = vld_q;
    job_d  = job_q;
    for (int i = 0; i < STAGES; i++) begin
      if (load[i]) begin
        vld_d[i] = up_vld;
        job_d[i] = rnd[i];
      end
      up_vld = vld_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    job_q <= job_d;
  end

  assign in_ready  = load[0];
  assign out_valid = vld_q[STAGES-1];
  assign tx_state  = job_q[STAGES-1].st;
  assign w_out     = job_q[STAGES-1].w;

endmodule
